// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared definitions for the EX-stage multiply/divide unit:
//   - md_op_e       : MdOp encodings (MULT, MULTU, DIV, DIVU)
//   - md_state_e    : sequencer state codes (IDLE, RUN, FIX)
//   - DIV_BY_ZERO_Q : quotient written to LO on a divide by zero
//   - small helpers to decode an MdOp value
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MDOP_MULT  = 2'b00,
        MDOP_MULTU = 2'b01,
        MDOP_DIV   = 2'b10,
        MDOP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

    // Bit 1 of MdOp selects divide, bit 0 selects the unsigned flavour.
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_md_step.sv
// -----------------------------------------------------------------------------
// muldiv_unit_md_step
// One combinational iteration of the multiply/divide datapath.
//
//   Multiply (is_div=0), shift-add, LSB-first:
//     acc       = partial product; the upper half receives the addend and the
//                 whole 64-bit value moves right one place per step
//     shift_in  = remaining multiplier bits (bit 0 is consumed this step)
//     operand   = multiplicand
//   Divide (is_div=1), restoring:
//     acc       = {remainder, dividend/quotient}; the dividend shifts out of
//                 the top of the low half while quotient bits shift in at bit 0
//     operand   = divisor
//     shift_in  = passed through unchanged
//
// Ports:
//   is_div    in   1        select divide iteration
//   acc_in    in   2*XLEN   current accumulator
//   operand   in   XLEN     multiplicand or divisor
//   shift_in  in   XLEN     remaining multiplier bits
//   acc_out   out  2*XLEN   next accumulator
//   shift_out out  XLEN     next multiplier bits
// -----------------------------------------------------------------------------
module muldiv_unit_md_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    input  logic [XLEN-1:0]   shift_in,
    output logic [2*XLEN-1:0] acc_out,
    output logic [XLEN-1:0]   shift_out
);

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_part;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;

    // Carry out of the add is kept: it becomes the MSB after the right shift.
    assign mul_sum  = {1'b0, acc_in[2*XLEN-1:XLEN]}
                    + {1'b0, (shift_in[0] ? operand : {XLEN{1'b0}})};

    // Partial remainder with the next dividend bit brought down. It can need
    // XLEN+1 bits, but after a successful subtract it always fits in XLEN.
    assign div_part = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1]};
    assign div_ge   = (div_part >= {1'b0, operand});
    assign div_diff = div_part[XLEN-1:0] - operand;

    always_comb begin
        acc_out   = '0;
        shift_out = '0;
        if (is_div) begin
            shift_out = shift_in;
            if (div_ge) begin
                acc_out = {div_diff, acc_in[XLEN-2:0], 1'b1};
            end else begin
                acc_out = {div_part[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_out   = {mul_sum, acc_in[XLEN-1:1]};
            shift_out = shift_in >> 1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit of the EX stage. Owns the HI/LO registers.
// An operation is launched from IDLE, iterates once per clock in RUN on
// operand magnitudes, and applies sign correction and the HI/LO write in FIX.
//
// Ports:
//   clk      in   1     pipeline clock
//   rst_n    in   1     asynchronous active-low reset
//   Start    in   1     launch an operation (sampled only when idle)
//   MdOp     in   2     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   DataIn1  in   XLEN  rs: multiplicand / dividend, also MTHI/MTLO data
//   DataIn2  in   XLEN  rt: multiplier / divisor
//   HiWe     in   1     MTHI write (idle only)
//   LoWe     in   1     MTLO write (idle only)
//   Flush    in   1     squash the in-flight operation
//   Busy     out  1     operation in flight
//   Done     out  1     one-cycle pulse after HI/LO were written
//   Hi       out  XLEN  HI register
//   Lo       out  XLEN  LO register
//
// Build option: defining MULDIV_EARLY_OUT_EN lets a multiply leave RUN as soon
// as the remaining multiplier bits are zero; the partial product is then
// realigned in FIX. Divide timing is the same either way.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Start,
    input  logic [1:0]      MdOp,
    input  logic [XLEN-1:0] DataIn1,
    input  logic [XLEN-1:0] DataIn2,
    input  logic            HiWe,
    input  logic            LoWe,
    input  logic            Flush,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Hi,
    output logic [XLEN-1:0] Lo
);

    md_state_e          state_reg, state_next;
    logic [1:0]         op_reg, op_next;
    logic [XLEN-1:0]    opa_reg, opa_next;        // multiplicand or divisor
    logic [XLEN-1:0]    shf_reg, shf_next;        // remaining multiplier bits
    logic [2*XLEN-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               neg_lo_reg, neg_lo_next;  // negate product / quotient
    logic               neg_hi_reg, neg_hi_next;  // negate remainder
    logic               dvz_reg, dvz_next;        // divide by zero
    logic               done_reg, done_next;
    logic [XLEN-1:0]    hi_reg, hi_next;
    logic [XLEN-1:0]    lo_reg, lo_next;

    // ---------------------------------------------------------------- launch
    logic            in_div, in_neg1, in_neg2, in_dvz;
    logic [XLEN-1:0] in_abs1, in_abs2;

    assign in_div  = md_is_div(MdOp);
    assign in_neg1 = md_is_signed(MdOp) & DataIn1[XLEN-1];
    assign in_neg2 = md_is_signed(MdOp) & DataIn2[XLEN-1];
    // Negating the most negative value yields itself, which read as unsigned
    // is exactly its magnitude.
    assign in_abs1 = in_neg1 ? -DataIn1 : DataIn1;
    assign in_abs2 = in_neg2 ? -DataIn2 : DataIn2;
    assign in_dvz  = in_div & (DataIn2 == '0);

    // ----------------------------------------------------------- iteration
    logic [2*XLEN-1:0] step_acc;
    logic [XLEN-1:0]   step_shf;

    muldiv_unit_md_step #(
        .XLEN(XLEN)
    ) u_md_step (
        .is_div    (op_reg[1]),
        .acc_in    (acc_reg),
        .operand   (opa_reg),
        .shift_in  (shf_reg),
        .acc_out   (step_acc),
        .shift_out (step_shf)
    );

    // ---------------------------------------------------------------- finish
    logic [XLEN-1:0]   fix_q, fix_r;
    logic [2*XLEN-1:0] mul_aligned;

    assign fix_q = acc_reg[XLEN-1:0];
    assign fix_r = acc_reg[2*XLEN-1:XLEN];

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
    // After n iterations the product sits n places short of its final
    // position; cnt holds n mod 2^CNT_W, so the missing shift is -cnt.
    // n = 0 only happens for a zero multiplier, where acc is zero anyway.
    logic [CNT_W-1:0] fix_shamt;
    assign fix_shamt   = CNT_W'(0) - cnt_reg;
    assign mul_aligned = acc_reg >> fix_shamt;
`else
    localparam bit EARLY_OUT = 1'b0;
    assign mul_aligned = acc_reg;
`endif

    // ------------------------------------------------------------- next state
    logic [2*XLEN-1:0] prod;

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        opa_next    = opa_reg;
        shf_next    = shf_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        neg_lo_next = neg_lo_reg;
        neg_hi_next = neg_hi_reg;
        dvz_next    = dvz_reg;
        done_next   = 1'b0;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        prod        = mul_aligned;

        case (state_reg)
            ST_IDLE: begin
                if (HiWe) hi_next = DataIn1;
                if (LoWe) lo_next = DataIn1;
                if (Start && !Flush) begin
                    op_next  = MdOp;
                    cnt_next = '0;
                    dvz_next = in_dvz;
                    if (in_div) begin
                        shf_next = '0;
                        if (in_dvz) begin
                            // Dividing the raw dividend by zero as unsigned
                            // leaves it intact as the remainder.
                            opa_next    = '0;
                            acc_next    = {{XLEN{1'b0}}, DataIn1};
                            neg_lo_next = 1'b0;
                            neg_hi_next = 1'b0;
                        end else begin
                            opa_next    = in_abs2;
                            acc_next    = {{XLEN{1'b0}}, in_abs1};
                            neg_lo_next = in_neg1 ^ in_neg2;
                            neg_hi_next = in_neg1;
                        end
                        state_next = ST_RUN;
                    end else begin
                        opa_next    = in_abs1;
                        shf_next    = in_abs2;
                        acc_next    = '0;
                        neg_lo_next = in_neg1 ^ in_neg2;
                        neg_hi_next = 1'b0;
                        if (EARLY_OUT && (in_abs2 == '0)) state_next = ST_FIX;
                        else                              state_next = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (Flush) begin
                    state_next = ST_IDLE;
                end else begin
                    acc_next = step_acc;
                    shf_next = step_shf;
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(XLEN - 1)) begin
                        state_next = ST_FIX;
                    end else if (EARLY_OUT && !op_reg[1] && (step_shf == '0)) begin
                        state_next = ST_FIX;
                    end
                end
            end

            ST_FIX: begin
                state_next = ST_IDLE;
                if (!Flush) begin
                    done_next = 1'b1;
                    if (op_reg[1]) begin
                        lo_next = dvz_reg    ? DIV_BY_ZERO_Q
                                : neg_lo_reg ? -fix_q : fix_q;
                        hi_next = neg_hi_reg ? -fix_r : fix_r;
                    end else begin
                        if (neg_lo_reg) prod = -mul_aligned;
                        hi_next = prod[2*XLEN-1:XLEN];
                        lo_next = prod[XLEN-1:0];
                    end
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            op_reg     <= '0;
            opa_reg    <= '0;
            shf_reg    <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            neg_lo_reg <= 1'b0;
            neg_hi_reg <= 1'b0;
            dvz_reg    <= 1'b0;
            done_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            opa_reg    <= opa_next;
            shf_reg    <= shf_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            neg_lo_reg <= neg_lo_next;
            neg_hi_reg <= neg_hi_next;
            dvz_reg    <= dvz_next;
            done_reg   <= done_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
        end
    end

    assign Busy = (state_reg != ST_IDLE);
    assign Done = done_reg;
    assign Hi   = hi_reg;
    assign Lo   = lo_reg;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit in the EX stage of the pipelined MIPS core.
- Sits downstream of the EX operand-forwarding mux, on the same operands that feed the ALU (DataIn1 = rs value, DataIn2 = rt value).
- Owns the architectural HI/LO registers.
- Hi/Lo feed the EX result mux for MFHI/MFLO; Busy feeds the hazard unit, which stalls IF/ID/EX.

Parameters:
- XLEN, 32, operand/result width; only 32 is verified.
- CNT_W, 5, iteration counter width; must equal log2(XLEN).

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  launch an operation; sampled only when Busy=0.
- MdOp  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- DataIn1  input  32  rs operand (multiplicand / dividend).
- DataIn2  input  32  rt operand (multiplier / divisor).
- HiWe  input  1  MTHI: write DataIn1 into HI.
- LoWe  input  1  MTLO: write DataIn1 into LO.
- Flush  input  1  abort the in-flight operation (branch/exception squash).
- Busy  output  1  operation in flight; hazard unit stalls any MF*/MT*/mul/div instruction while it is high.
- Done  output  1  one-cycle pulse; Hi/Lo were updated on this edge.
- Hi  output  32  HI register.
- Lo  output  32  LO register.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; Busy=0; Done=0; Hi=0; Lo=0; counter and internal accumulators=0. Reset mid-operation discards the operation with no HI/LO update.
- FSM states: IDLE, RUN, FIX.
- IDLE -> RUN: on an edge with Start=1.
  - Latch MdOp.
  - Latch |DataIn1| and |DataIn2|; absolute value only for signed ops. abs(0x80000000) is treated as unsigned 0x80000000.
  - Latch the result sign bits.
  - cnt=0.
- RUN:
  - One iteration per edge: shift-add for multiply, restoring subtract-shift for divide.
  - cnt increments each edge.
  - After the iteration with cnt=31 -> FIX.
- FIX (one edge):
  - Apply two's-complement sign correction.
  - Write HI/LO, pulse Done, return to IDLE.
- Latency (Start sampled on edge k): RUN covers edges k+1..k+32; FIX on edge k+33.
  - Busy=1 from after edge k until edge k+33.
  - Done=1 and new Hi/Lo visible for the single cycle after edge k+33, with Busy=0 in that cycle.
  - A new Start is accepted in the Done cycle (back-to-back throughput is 34 cycles).
- Multiply results: {Hi,Lo} = 64-bit product. MULT is signed, MULTU unsigned.
- Divide results: Lo = quotient truncated toward zero; Hi = remainder carrying the sign of the dividend.
- Divide by zero (DataIn2=0, DIV or DIVU):
  - Normal 34-cycle timing.
  - Lo=0xFFFFFFFF, Hi=DataIn1 (raw dividend).
  - No exception is raised.
- DIV 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0.
- Start while Busy=1: ignored; the in-flight operation continues.
- HiWe/LoWe:
  - Honoured only when Busy=0; write on the same edge.
  - HiWe together with Start in IDLE: the write happens and the operation launches. Its later result overwrites HI.
  - Ignored while Busy=1; the hazard unit guarantees this never happens in legal flow.
- Flush:
  - In RUN or FIX: state -> IDLE on the next edge, Hi/Lo unchanged, no Done.
  - Flush has priority over FIX completion.
  - Flush together with Start in IDLE: Start is ignored.
- Done and Busy are registered outputs with no combinational input-to-output path. Hi/Lo are registers.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - Multiply leaves RUN as soon as the remaining multiplier bits are all zero; the partial product is shifted into its final alignment in FIX.
  - Latency for a multiply = 2 + (index of the highest set bit of |multiplier|) + 1 cycles. Multiplier 0 takes 2 cycles.
  - Divide timing is unchanged.
- Undefined: fixed 34-cycle latency for all operations.

Decomposition:
- Shared definitions header, alongside the existing ALU op encodings:
  - MDOp_MULT/MULTU/DIV/DIVU encodings.
  - FSM state codes.
  - Divide-by-zero quotient constant 32'hFFFFFFFF.
- Natural sub-module: md_step. A combinational single iteration: given acc, operand, and mode, it returns the next acc/shift values for both multiply and divide.
- The top level holds the FSM, counter, sign logic and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF x 0x00000002: Done at cycle 34 with Hi=0x00000001, Lo=0xFFFFFFFE. Busy high for cycles 1..33.
- MULT 0xFFFFFFFF x 0x00000002: Hi=0xFFFFFFFF, Lo=0xFFFFFFFE. MULT 0x80000000 x 0x80000000: Hi=0x40000000, Lo=0.
- DIV 0xFFFFFFF9 (-7) / 2: Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 100 / 7: Lo=0x0000000E, Hi=0x00000002.
- DIVU 0x12345678 / 0: Lo=0xFFFFFFFF, Hi=0x12345678, Done at cycle 34.
- Start MULTU 3x5 after MTHI 0xAAAA0000; assert Flush at cycle 10: Busy=0 at cycle 11, no Done, Hi=0xAAAA0000 and Lo unchanged. Next Start 3x5 gives Lo=15, Hi=0.
- Drop rst_n at cycle 20 of a DIV: Busy, Done, Hi, Lo go to 0 immediately (asynchronously). Start with Busy=1 is ignored and the original result is unchanged.
